// File: rtl/frame_drain_ctrl_pkg.sv
// Shared definitions for the egress frame drain controller: pointer word layout,
// FSM encoding and default frame length limits.
package frame_drain_ctrl_pkg;

  localparam int unsigned PtrLenMsb = 10;
  localparam int unsigned PtrSrcLsb = 11;
  localparam int unsigned PtrErrBit = 15;

  localparam int unsigned MinLenDef = 60;
  localparam int unsigned MaxLenDef = 1518;

  typedef enum logic [5:0] {
    StIdle   = 6'b000001,
    StPtrRd  = 6'b000010,
    StPtrLat = 6'b000100,
    StHdr    = 6'b001000,
    StFwd    = 6'b010000,
    StDrop   = 6'b100000
  } state_e;

  function automatic logic is_onehot4(logic [3:0] v);
    return (v != 4'b0) && ((v & (v - 4'd1)) == 4'b0);
  endfunction

endpackage

// File: rtl/frame_drain_ctrl_if.sv
// FIFO-side and stream-side signals of the frame drain controller.
// master: the controller; slave: the FIFOs and downstream stage.
interface frame_drain_ctrl_if;
  logic        ptr_sfifo_empty;
  logic        ptr_sfifo_rd;
  logic [15:0] ptr_sfifo_dout;
  logic        sfifo_rd;
  logic [7:0]  sfifo_dout;
  logic [3:0]  src_en;
  logic        frm_valid;
  logic        frm_ready;
  logic [7:0]  frm_data;
  logic        frm_sop;
  logic        frm_eop;
  logic [3:0]  frm_src;
  logic        drop_pulse;

  modport master (
    input  ptr_sfifo_empty, ptr_sfifo_dout, sfifo_dout, src_en, frm_ready,
    output ptr_sfifo_rd, sfifo_rd, frm_valid, frm_data, frm_sop, frm_eop, frm_src, drop_pulse
  );

  modport slave (
    output ptr_sfifo_empty, ptr_sfifo_dout, sfifo_dout, src_en, frm_ready,
    input  ptr_sfifo_rd, sfifo_rd, frm_valid, frm_data, frm_sop, frm_eop, frm_src, drop_pulse
  );
endinterface

// File: rtl/frame_drain_ctrl_fwd_skid_buf.sv
// fwd_skid_buf: 2-entry output buffer with valid/ready and occupancy, synchronous reset.
module fwd_skid_buf #(
  parameter int unsigned Width = 10
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [Width-1:0] data_o,
  output logic [1:0]       occ_o
);

  logic [Width-1:0] mem_q [2];
  logic             wr_q, rd_q;
  logic [1:0]       cnt_q;
  logic             push, pop;

  assign pop  = valid_o && ready_i;
  assign push = push_i && (cnt_q != 2'd2);

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_q  <= 1'b0;
      rd_q  <= 1'b0;
      cnt_q <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= ~wr_q;
      end
      if (pop) rd_q <= ~rd_q;
      cnt_q <= cnt_q + {1'b0, push} - {1'b0, pop};
    end
  end

  assign valid_o = (cnt_q != 2'd0);
  assign data_o  = valid_o ? mem_q[rd_q] : '0;
  assign occ_o   = cnt_q;

endmodule

// File: rtl/frame_drain_ctrl.sv
// Egress frame drain controller: pops a pointer word, then forwards or silently drains the frame.
// Define FRAME_DRAIN_STATS_EN to add per-source forwarded/dropped frame counters.
module frame_drain_ctrl
  import frame_drain_ctrl_pkg::*;
#(
  parameter int unsigned MinLen = MinLenDef,
  parameter int unsigned MaxLen = MaxLenDef
) (
  input  logic                clk_sys,
  input  logic                rstn_sys,
`ifdef FRAME_DRAIN_STATS_EN
  input  logic                stat_clr,
  output logic [127:0]        stat_fwd_cnt,
  output logic [127:0]        stat_drop_cnt,
`endif
  frame_drain_ctrl_if.master  bus
);

  localparam logic [10:0] MinLenW = 11'(MinLen);
  localparam logic [10:0] MaxLenW = 11'(MaxLen);

  state_e      state_q, state_d;
  logic [10:0] len_q, len_d, cnt_q, cnt_d;
  logic [3:0]  src_q, src_d;
  logic        pend_q, pend_d, tag_sop_q, tag_sop_d, tag_eop_q, tag_eop_d;
  logic        drop_pulse_q, drop_pulse_d;

  logic [10:0] ptr_len;
  logic [3:0]  ptr_src;
  logic        ptr_err, hdr_drop;
  logic        rd_fwd, rd_drop, pop;
  logic [2:0]  fill;

  logic        skid_valid;
  logic [9:0]  skid_word;
  logic [1:0]  skid_occ;

  assign ptr_len  = bus.ptr_sfifo_dout[PtrLenMsb:0];
  assign ptr_src  = bus.ptr_sfifo_dout[PtrSrcLsb +: 4];
  assign ptr_err  = bus.ptr_sfifo_dout[PtrErrBit];
  assign hdr_drop = (ptr_len < MinLenW) || (ptr_len > MaxLenW) || !is_onehot4(ptr_src) ||
                    ptr_err || ((ptr_src & bus.src_en) == 4'b0);

  assign pop = skid_valid && bus.frm_ready;
  // Entries the buffer will hold next cycle; a new read is only issued if its byte will fit.
  assign fill = {1'b0, skid_occ} + {2'b0, pend_q} - {2'b0, pop};

  always_comb begin
    state_d      = state_q;
    len_d        = len_q;
    src_d        = src_q;
    cnt_d        = cnt_q;
    drop_pulse_d = 1'b0;
    rd_fwd       = 1'b0;
    rd_drop      = 1'b0;
    unique case (state_q)
      StIdle:   if (!bus.ptr_sfifo_empty) state_d = StPtrRd;
      StPtrRd:  state_d = StPtrLat;
      StPtrLat: state_d = StHdr;
      StHdr: begin
        len_d        = ptr_len;
        src_d        = ptr_src;
        cnt_d        = '0;
        drop_pulse_d = hdr_drop;
        state_d      = hdr_drop ? StDrop : StFwd;
      end
      StFwd: begin
        rd_fwd = (cnt_q != len_q) && (fill < 3'd2);
        if (pop && skid_word[8]) state_d = StIdle;
      end
      StDrop: begin
        rd_drop = (cnt_q != len_q);
        if ((len_q == 11'd0) || (cnt_q == len_q - 11'd1)) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
    if (rd_fwd || rd_drop) cnt_d = cnt_q + 11'd1;
  end

  assign pend_d    = rd_fwd;
  assign tag_sop_d = (cnt_q == 11'd0);
  assign tag_eop_d = (cnt_q == len_q - 11'd1);

  always_ff @(posedge clk_sys) begin
    if (!rstn_sys) begin
      state_q      <= StIdle;
      len_q        <= '0;
      src_q        <= '0;
      cnt_q        <= '0;
      pend_q       <= 1'b0;
      tag_sop_q    <= 1'b0;
      tag_eop_q    <= 1'b0;
      drop_pulse_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      len_q        <= len_d;
      src_q        <= src_d;
      cnt_q        <= cnt_d;
      pend_q       <= pend_d;
      tag_sop_q    <= tag_sop_d;
      tag_eop_q    <= tag_eop_d;
      drop_pulse_q <= drop_pulse_d;
    end
  end

  fwd_skid_buf #(
    .Width (10)
  ) u_skid (
    .clk_i   (clk_sys),
    .rst_ni  (rstn_sys),
    .push_i  (pend_q),
    .data_i  ({tag_sop_q, tag_eop_q, bus.sfifo_dout}),
    .ready_i (bus.frm_ready),
    .valid_o (skid_valid),
    .data_o  (skid_word),
    .occ_o   (skid_occ)
  );

  assign bus.ptr_sfifo_rd = (state_q == StPtrRd);
  assign bus.sfifo_rd     = rd_fwd || rd_drop;
  assign bus.frm_valid    = skid_valid;
  assign bus.frm_sop      = skid_word[9];
  assign bus.frm_eop      = skid_word[8];
  assign bus.frm_data     = skid_word[7:0];
  assign bus.frm_src      = skid_valid ? src_q : 4'b0;
  assign bus.drop_pulse   = drop_pulse_q;

`ifdef FRAME_DRAIN_STATS_EN
  logic [3:0][31:0] fwd_cnt_q, drop_cnt_q;
  logic             fwd_done, drop_start;

  assign fwd_done   = (state_q == StFwd) && pop && skid_word[8];
  assign drop_start = (state_q == StHdr) && hdr_drop;

  always_ff @(posedge clk_sys) begin
    if (!rstn_sys || stat_clr) begin
      fwd_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (fwd_done && src_q[i] && (fwd_cnt_q[i] != '1)) fwd_cnt_q[i] <= fwd_cnt_q[i] + 32'd1;
        if (drop_start && ptr_src[i] && (drop_cnt_q[i] != '1)) begin
          drop_cnt_q[i] <= drop_cnt_q[i] + 32'd1;
        end
      end
    end
  end

  assign stat_fwd_cnt  = fwd_cnt_q;
  assign stat_drop_cnt = drop_cnt_q;
`endif

endmodule
